// File: rtl/sdrx_frame.sv
// SD-style block receiver: waits for a start bit, packs 1/4/8 lanes into 32-bit words,
// then checks the per-lane CRC16 trailer and the stop bit.
module sdrx_frame #(
    parameter int LGTIMEOUT = 20,
    parameter int NCRC      = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_width,
    input  logic [11:0] i_length,
    input  logic        i_rx_stb,
    input  logic [7:0]  i_rx_dat,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_last,
    output logic        o_done,
    output logic        o_err,
    output logic        o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_DATA,
        S_CRC,
        S_STOP
    } state_t;

    localparam logic [NCRC-1:0] CRC_POLY = NCRC'(16'h1021);

    state_t                 state, state_nxt;
    logic [1:0]             width_r;
    logic [9:0]             words_left;
    logic [4:0]             samp_left;
    logic [LGTIMEOUT-1:0]   tmr;
    logic [31:0]            shreg, shreg_nxt;
    logic [NCRC-1:0]        crc     [8];
    logic [NCRC-1:0]        crc_nxt [8];
    logic                   err_sticky;

    logic [7:0] lane_mask, act;
    logic       start_ok, start_bit, timeout_hit, word_done, last_word;
    logic       crc_done, crc_bad, stop_hit, stop_bad;

    function automatic logic [4:0] spw_m1(input logic [1:0] w);
        case (w)
            2'b00:   return 5'd31;
            2'b01:   return 5'd7;
            default: return 5'd3;
        endcase
    endfunction

    assign o_busy = (state != S_IDLE);

    always_comb begin
        case (width_r)
            2'b00:   lane_mask = 8'h01;
            2'b01:   lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
        act         = i_rx_dat & lane_mask;
        // the cycle that reports o_done is already IDLE, so it must not re-arm
        start_ok    = i_start && (state == S_IDLE) && !o_done;
        start_bit   = (state == S_WAIT_START) && i_rx_stb && (act == 8'h00);
        timeout_hit = (state == S_WAIT_START) && !start_bit && (tmr == '0);
        word_done   = (state == S_DATA) && i_rx_stb && (samp_left == 5'd0);
        last_word   = word_done && (words_left == 10'd1);
        crc_done    = (state == S_CRC) && i_rx_stb && (samp_left == 5'd0);
        stop_hit    = (state == S_STOP) && i_rx_stb;
        stop_bad    = (act != lane_mask);

        case (width_r)
            2'b00:   shreg_nxt = {shreg[30:0], i_rx_dat[0]};
            2'b01:   shreg_nxt = {shreg[27:0], i_rx_dat[3:0]};
            default: shreg_nxt = {shreg[23:0], i_rx_dat[7:0]};
        endcase

        crc_bad = 1'b0;
        for (int l = 0; l < 8; l++) begin
            crc_nxt[l] = crc[l];
            if (lane_mask[l]) begin
                if (state == S_DATA) begin
                    crc_nxt[l] = {crc[l][NCRC-2:0], 1'b0}
                               ^ ((crc[l][NCRC-1] ^ i_rx_dat[l]) ? CRC_POLY : '0);
                end else if (state == S_CRC) begin
                    // trailer arrives MSB first, so compare against the top bit and shift out
                    crc_nxt[l] = {crc[l][NCRC-2:0], 1'b0};
                    if (i_rx_dat[l] != crc[l][NCRC-1]) crc_bad = 1'b1;
                end
            end
        end

        state_nxt = state;
        case (state)
            S_IDLE:       if (start_ok) state_nxt = S_WAIT_START;
            S_WAIT_START: begin
                if (start_bit)        state_nxt = S_DATA;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_DATA:       if (last_word) state_nxt = S_CRC;
            S_CRC:        if (crc_done)  state_nxt = S_STOP;
            S_STOP:       if (stop_hit)  state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_last     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_timeout  <= 1'b0;
            width_r    <= '0;
            words_left <= '0;
            samp_left  <= '0;
            tmr        <= '0;
            shreg      <= '0;
            err_sticky <= 1'b0;
            for (int l = 0; l < 8; l++) crc[l] <= '0;
        end else begin
            o_valid   <= word_done;
            o_last    <= last_word;
            o_done    <= timeout_hit || stop_hit;
            o_timeout <= timeout_hit;
            o_err     <= timeout_hit || (stop_hit && (err_sticky || stop_bad));
            if (word_done) o_data <= shreg_nxt;

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        width_r    <= i_width;
                        // a ragged tail still occupies a whole word
                        words_left <= i_length[11:2] + {9'd0, |i_length[1:0]};
                        samp_left  <= spw_m1(i_width);
                        tmr        <= '1;
                    end
                end
                S_WAIT_START: begin
                    tmr        <= tmr - LGTIMEOUT'(1);
                    err_sticky <= 1'b0;
                    shreg      <= '0;
                    for (int l = 0; l < 8; l++) crc[l] <= '0;
                end
                S_DATA: begin
                    if (i_rx_stb) begin
                        shreg <= shreg_nxt;
                        crc   <= crc_nxt;
                        if (samp_left == 5'd0) begin
                            samp_left  <= last_word ? 5'(NCRC - 1) : spw_m1(width_r);
                            words_left <= words_left - 10'd1;
                        end else begin
                            samp_left  <= samp_left - 5'd1;
                        end
                    end
                end
                S_CRC: begin
                    if (i_rx_stb) begin
                        crc       <= crc_nxt;
                        samp_left <= samp_left - 5'd1;
                        if (crc_bad) err_sticky <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdrx_frame.sv
// Randomized bench for sdrx_frame: builds whole pin-sample streams from word lists,
// then compares received words, strobe-relative timing and completion status.
module tb_sdrx_frame;

    logic        i_clk = 1'b0;
    logic        i_reset, i_start, i_rx_stb;
    logic [1:0]  i_width;
    logic [11:0] i_length;
    logic [7:0]  i_rx_dat;
    logic        o_busy, o_valid, o_last, o_done, o_err, o_timeout;
    logic [31:0] o_data;

    always #5 i_clk = ~i_clk;

    sdrx_frame #(.LGTIMEOUT(4), .NCRC(16)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_width  (i_width),
        .i_length (i_length),
        .i_rx_stb (i_rx_stb),
        .i_rx_dat (i_rx_dat),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_last   (o_last),
        .o_done   (o_done),
        .o_err    (o_err),
        .o_timeout(o_timeout)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    logic [31:0] got_data [$];
    bit          got_last [$];
    int unsigned got_vcyc [$];
    int          n_done = 0;
    bit          done_err, done_to;
    int unsigned done_cyc;

    always @(negedge i_clk) begin
        if (o_valid) begin
            got_data.push_back(o_data);
            got_last.push_back(o_last);
            got_vcyc.push_back(cyc);
        end
        if (o_done) begin
            n_done   = n_done + 1;
            done_err = o_err;
            done_to  = o_timeout;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    logic [31:0] words  [$];
    logic [7:0]  stream [$];
    int unsigned scyc   [$];

    task automatic run_block(input logic [1:0] w, input int corrupt_lane, input bit stop_bad,
                             input bit gaps);
        int          bpl, spw, nw, vb, db, crc_k, nv;
        logic [7:0]  mask, smp;
        logic [15:0] crc [8];
        bpl  = (w == 2'd0) ? 1 : (w == 2'd1) ? 4 : 8;
        spw  = 32 / bpl;
        nw   = words.size();
        mask = (w == 2'd0) ? 8'h01 : (w == 2'd1) ? 8'h0F : 8'hFF;
        stream.delete();
        scyc.delete();
        stream.push_back(8'($urandom) & ~mask);
        for (int l = 0; l < 8; l++) crc[l] = 16'h0;
        for (int k = 0; k < nw; k++) begin
            for (int s = 0; s < spw; s++) begin
                smp = (8'($urandom) & ~mask) | (8'(words[k] >> (32 - (s + 1) * bpl)) & mask);
                for (int l = 0; l < bpl; l++) crc[l] = crc_step(crc[l], smp[l]);
                stream.push_back(smp);
            end
        end
        crc_k = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) begin
            smp = 8'($urandom) & ~mask;
            for (int l = 0; l < bpl; l++) begin
                smp[l] = crc[l][15 - k];
                if (l == corrupt_lane && k == crc_k) smp[l] = ~smp[l];
            end
            stream.push_back(smp);
        end
        smp = (8'($urandom) & ~mask) | mask;
        if (stop_bad) smp[0] = 1'b0;
        stream.push_back(smp);

        vb = got_data.size();
        db = n_done;
        repeat (2) begin
            i_rx_stb = 1'b1;
            i_rx_dat = 8'($urandom);
            @(negedge i_clk);
        end
        i_rx_stb = 1'b0;
        i_start  = 1'b1;
        i_width  = w;
        i_length = 12'(nw * 4);
        @(negedge i_clk);
        i_start  = 1'b0;
        i_width  = (w == 2'd0) ? 2'd2 : 2'd0;
        i_length = 12'd4;
        chk("busy_after_start", o_busy, 1);
        for (int i = 0; i < stream.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    i_rx_stb = 1'b0;
                    i_rx_dat = 8'($urandom);
                    @(negedge i_clk);
                end
            end
            if (i == 2) i_start = 1'b1;
            i_rx_stb = 1'b1;
            i_rx_dat = stream[i];
            scyc.push_back(cyc);
            @(negedge i_clk);
            i_start = 1'b0;
        end
        i_rx_stb = 1'b0;
        chk("done_after_stop", o_done, 1);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("start_on_done_ignored", o_busy, 0);
        repeat (2) @(negedge i_clk);

        nv = got_data.size() - vb;
        chk("word_count", nv, nw);
        for (int k = 0; k < nw && k < nv; k++) begin
            chk($sformatf("word%0d_data", k), got_data[vb + k], words[k]);
            chk($sformatf("word%0d_last", k), got_last[vb + k], (k == nw - 1));
            chk($sformatf("word%0d_cycle", k), got_vcyc[vb + k], scyc[(k + 1) * spw] + 1);
        end
        chk("done_count", n_done - db, 1);
        chk("done_err", done_err, (corrupt_lane >= 0) || stop_bad);
        chk("done_timeout", done_to, 0);
        chk("done_cycle", done_cyc, scyc[stream.size() - 1] + 1);
    endtask

    task automatic run_timeout(input bit mixed);
        int          vb, db, n;
        int unsigned sc;
        vb = got_data.size();
        db = n_done;
        i_start  = 1'b1;
        i_width  = 2'd1;
        i_length = 12'd8;
        sc = cyc;
        @(negedge i_clk);
        i_start  = 1'b0;
        i_rx_stb = 1'b1;
        n = 0;
        while (n_done == db && n < 40) begin
            i_rx_dat = (8'($urandom) & 8'hF0) | (mixed ? 8'($urandom_range(1, 15)) : 8'h0F);
            @(negedge i_clk);
            n++;
        end
        i_rx_stb = 1'b0;
        chk("timeout_done_seen", n_done - db, 1);
        // i_start is sampled on the edge ending cycle sc; o_done is registered 2^4 edges later
        chk("timeout_latency", done_cyc - (sc + 1), 16);
        chk("timeout_err", done_err, 1);
        chk("timeout_flag", done_to, 1);
        chk("timeout_no_valid", got_data.size() - vb, 0);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_last"}, o_last, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_timeout"}, o_timeout, 0);
        chk({tag, "_data"}, o_data, 0);
    endtask

    initial begin
        int db, nw;
        logic [31:0] base;
        i_reset  = 1'b1;
        i_start  = 1'b0;
        i_width  = 2'd0;
        i_length = 12'd4;
        i_rx_stb = 1'b0;
        i_rx_dat = 8'h00;
        repeat (3) @(negedge i_clk);
        chk_all_zero("reset");
        i_reset = 1'b0;
        @(negedge i_clk);

        words.delete();
        words.push_back(32'hA5A5_0F0F);
        run_block(2'd0, -1, 1'b0, 1'b0);

        words.delete();
        base = $urandom;
        for (int k = 0; k < 128; k++) words.push_back(base + 32'(k));
        run_block(2'd1, -1, 1'b0, 1'b0);

        words.delete();
        repeat (2) words.push_back($urandom);
        run_block(2'd2, 5, 1'b0, 1'b0);

        run_timeout(1'b0);
        run_timeout(1'b1);

        words.delete();
        words.push_back($urandom);
        run_block(2'd0, -1, 1'b1, 1'b0);

        // abort mid-DATA, then restart on the very first edge out of reset
        db = n_done;
        i_start  = 1'b1;
        i_width  = 2'd0;
        i_length = 12'd8;
        @(negedge i_clk);
        i_start  = 1'b0;
        i_rx_stb = 1'b1;
        i_rx_dat = 8'hFE;
        @(negedge i_clk);
        repeat (10) begin
            i_rx_dat = 8'($urandom);
            @(negedge i_clk);
        end
        i_rx_stb = 1'b0;
        i_reset  = 1'b1;
        @(negedge i_clk);
        chk_all_zero("abort");
        @(negedge i_clk);
        i_reset  = 1'b0;
        i_start  = 1'b1;
        i_width  = 2'd0;
        i_length = 12'd4;
        @(negedge i_clk);
        i_start = 1'b0;
        chk("restart_busy", o_busy, 1);
        chk("abort_no_done", n_done - db, 0);
        repeat (20) @(negedge i_clk);

        for (int w = 0; w < 3; w++) begin
            for (int r = 0; r < 2; r++) begin
                words.delete();
                nw = (w == 0) ? $urandom_range(1, 2) : $urandom_range(1, 5);
                repeat (nw) words.push_back($urandom);
                run_block(2'(w), -1, 1'b0, 1'b1);
            end
        end

        words.delete();
        repeat (3) words.push_back($urandom);
        run_block(2'd1, $urandom_range(0, 3), 1'b0, 1'b1);

        words.delete();
        for (int k = 0; k < 512; k++) words.push_back($urandom);
        run_block(2'd2, -1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdrx_frame.md
SDRX_FRAME -- requirements
Module: sdrx_frame

Interface
REQ-001 SHALL provide parameter LGTIMEOUT, default 20, meaning log2 of the clock-cycle limit while waiting for a start bit.
REQ-002 SHALL provide parameter NCRC, default 16, meaning the CRC width per lane (polynomial 16'h1021).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  synchronous active-high reset.
REQ-006 i_start  input  1  one-cycle request to receive one data block.
REQ-007 i_width  input  2  bus width: 00 = 1b, 01 = 4b, 1x = 8b; sampled at i_start.
REQ-008 i_length  input  12  block length in bytes, a multiple of 4 from 4 to 2048; sampled at i_start.
REQ-009 i_rx_stb  input  1  qualifies i_rx_dat as one new SDR pin sample.
REQ-010 i_rx_dat  input  8  sampled sd_dat[7:0]; unused lanes are ignored.
REQ-011 o_busy  output  1  high from accepted i_start until o_done.
REQ-012 o_valid  output  1  one-cycle pulse, o_data holds a completed word; no backpressure.
REQ-013 o_data  output  32  received word, first sample in MSBs.
REQ-014 o_last  output  1  asserted with o_valid on the final word of the block.
REQ-015 o_done  output  1  one-cycle pulse at block completion or failure.
REQ-016 o_err  output  1  valid with o_done: CRC, stop-bit or timeout failure.
REQ-017 o_timeout  output  1  valid with o_done: the failure was a start-bit timeout.

Function
REQ-018 SHALL implement states IDLE, WAIT_START, DATA, CRC, STOP; all transitions advance only on i_rx_stb, except the timeout and abort paths.
REQ-019 IDLE: i_start moves to WAIT_START and latches width and length; i_start while o_busy is ignored.
REQ-020 WAIT_START: a sample with every active lane 0 moves to DATA (lane 0 in 1b; lanes 3:0 in 4b; lanes 7:0 in 8b); a mixed-zero sample is not a start bit.
REQ-021 WAIT_START: 2^LGTIMEOUT i_clk cycles without a start bit SHALL end the block with o_done=1, o_err=1, o_timeout=1.
REQ-022 DATA: shift active lanes into a 32-bit register.
REQ-023 DATA packing: 1b appends dat[0]; 4b appends dat[3:0]; 8b appends dat[7:0].
REQ-024 DATA word rate: one word every 32, 8 or 4 samples for 1b, 4b and 8b respectively.
REQ-025 o_valid SHALL pulse the cycle after the sample that completes a word.
REQ-026 o_last SHALL be set when the count of words emitted equals i_length/4; after that word, move to CRC.
REQ-027 Each active lane L SHALL run CRC16 over its data bits: next = {crc[14:0],0} ^ (crc[15]^bit ? 16'h1021 : 0). The CRC is cleared in WAIT_START.
REQ-028 CRC state: capture 16 samples per lane and compare each lane against its computed CRC. Any mismatch sets a sticky error.
REQ-029 STOP: one sample; any active lane at 0 sets the sticky error. Then return to IDLE with o_done=1, o_err=sticky, o_timeout=0.
REQ-030 The word counter SHALL be 10 bits; i_length=2048 yields 512 words with no wrap.
REQ-031 i_start coincident with o_done SHALL be ignored; a new request is accepted from IDLE only.
REQ-032 An i_reset assertion mid-block SHALL abort immediately with no o_done, o_valid or o_last.
REQ-033 Samples arriving while IDLE SHALL have no effect.
REQ-034 Lanes not selected by width SHALL affect neither data, CRC nor stop checks.

Reset
REQ-035 On i_reset: state=IDLE; o_busy, o_valid, o_last, o_done, o_err and o_timeout = 0; o_data, CRCs, counters and the sticky error = 0.
REQ-036 After reset release, the first i_start SHALL be accepted on the next clock.

Verification
REQ-037 1b, i_length=4, word 32'hA5A5_0F0F plus correct CRC and stop bit -> one o_valid with o_data=A5A50F0F, o_last=1, then o_done=1, o_err=0.
REQ-038 4b, i_length=512, incrementing words with correct per-lane CRC -> 128 o_valid pulses, o_last only on word 127, o_done=1, o_err=0.
REQ-039 8b, i_length=8, lane 5 CRC bit flipped -> 2 correct words, then o_done=1, o_err=1, o_timeout=0.
REQ-040 4b, dat[3:0]=4'hF held, LGTIMEOUT=4 -> o_done=1, o_err=1, o_timeout=1 exactly 16 cycles after i_start; no o_valid.
REQ-041 1b, stop bit driven 0 -> o_done=1, o_err=1; i_reset asserted mid-DATA on a second block -> all outputs 0 next cycle and no o_done.
REQ-042 Random i_rx_stb gaps (0-3 idle cycles) in all three widths -> data and o_done timing identical to the gap-free run.
